// File: rtl/logic_rs_if.sv
// Dispatch, CDB snoop and result handshake bundle for the logic reservation station.
// Latency: none, wires only.
// Backpressure: disp_ready throttles dispatch; res_ready throttles result drain.
interface logic_rs_if #(
  parameter int TAG_W = 4,
  parameter int DW    = 64
);
  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_op;
  logic [TAG_W-1:0] disp_dest;
  logic [DW-1:0]    disp_vj;
  logic [DW-1:0]    disp_vk;
  logic             disp_qj_v;
  logic             disp_qk_v;
  logic [TAG_W-1:0] disp_qj;
  logic [TAG_W-1:0] disp_qk;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [DW-1:0]    cdb_data;

  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [DW-1:0]    res_data;
  logic             res_ready;

  // Dispatcher / CDB / arbiter side
  modport master (
    output disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
    output disp_qj_v, disp_qk_v, disp_qj, disp_qk,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  res_valid, res_tag, res_data,
    output res_ready
  );

  // Reservation station side
  modport slave (
    input  disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
    input  disp_qj_v, disp_qk_v, disp_qj, disp_qk,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output res_valid, res_tag, res_data,
    input  res_ready
  );
endinterface

// File: rtl/logic_rs.sv
// logic_unit: 64-bit bitwise function unit.
// Latency: combinational.
// Backpressure: none.
module logic_unit (
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);
  // Opcode decode: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (a & ~b), 7 pass a
  always_comb begin
    y = '0;
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a | b);
      3'd4:    y = ~(a & b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = a & ~b;
      default: y = a;
    endcase
  end
endmodule

// logic_rs: reservation station plus execute stage for the logic unit, snooping the CDB.
// Latency: dispatch with ready operands in cycle T gives res_valid in T+2; 1 op/cycle sustained.
// Backpressure: disp_ready low when all entries busy; result held while res_ready is low.
module logic_rs #(
  parameter int N_ENT = 4,
  parameter int TAG_W = 4,
  parameter int DW    = 64   // logic_unit is 64 bits wide; DW must stay 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logic_rs_if.slave               rs,
  output logic [$clog2(N_ENT):0]  busy_cnt
);
  localparam int IDX_W = $clog2(N_ENT);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             busy;
    logic [2:0]       op;
    logic [TAG_W-1:0] dest;
    logic [DW-1:0]    vj;
    logic [DW-1:0]    vk;
    logic             qj_v;
    logic             qk_v;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } ent_t;

  ent_t             ent_q [N_ENT];
  ent_t             new_ent;
  logic             free_hit;
  logic [IDX_W-1:0] free_idx;
  logic             iss_hit;
  logic [IDX_W-1:0] iss_idx;
  logic             disp_fire;
  logic             can_issue;
  logic             issue_fire;
  logic [63:0]      lu_y;
  logic             res_valid_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [DW-1:0]    res_data_q;
  logic [CNT_W-1:0] cnt_q;

  // Lowest-index free entry and lowest-index ready entry, both from registered state only
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    iss_hit  = 1'b0;
    iss_idx  = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_q[i].busy && !ent_q[i].qj_v && !ent_q[i].qk_v) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  assign disp_fire  = rs.disp_valid && free_hit;
  assign can_issue  = !res_valid_q || rs.res_ready;
  assign issue_fire = iss_hit && can_issue;

  // New entry image, taking operands straight off the CDB when their tag is broadcast this cycle
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.op   = rs.disp_op;
    new_ent.dest = rs.disp_dest;
    new_ent.vj   = rs.disp_vj;
    new_ent.vk   = rs.disp_vk;
    new_ent.qj_v = rs.disp_qj_v;
    new_ent.qk_v = rs.disp_qk_v;
    new_ent.qj   = rs.disp_qj;
    new_ent.qk   = rs.disp_qk;
    if (rs.disp_qj_v && rs.cdb_valid && (rs.disp_qj == rs.cdb_tag)) begin
      new_ent.vj   = rs.cdb_data;
      new_ent.qj_v = 1'b0;
    end
    if (rs.disp_qk_v && rs.cdb_valid && (rs.disp_qk == rs.cdb_tag)) begin
      new_ent.vk   = rs.cdb_data;
      new_ent.qk_v = 1'b0;
    end
  end

  logic_unit u_lu (
    .op (ent_q[iss_idx].op),
    .a  (ent_q[iss_idx].vj),
    .b  (ent_q[iss_idx].vk),
    .y  (lu_y)
  );

  // Entry state: free on issue, capture pending operands from the CDB, fill on dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        if (issue_fire && (iss_idx == IDX_W'(i))) begin
          ent_q[i].busy <= 1'b0;
        end else if (ent_q[i].busy) begin
          if (rs.cdb_valid && ent_q[i].qj_v && (ent_q[i].qj == rs.cdb_tag)) begin
            ent_q[i].vj   <= rs.cdb_data;
            ent_q[i].qj_v <= 1'b0;
          end
          if (rs.cdb_valid && ent_q[i].qk_v && (ent_q[i].qk == rs.cdb_tag)) begin
            ent_q[i].vk   <= rs.cdb_data;
            ent_q[i].qk_v <= 1'b0;
          end
        end else if (disp_fire && (free_idx == IDX_W'(i))) begin
          ent_q[i] <= new_ent;
        end
      end
    end
  end

  // Result register: load on issue (back-to-back with an accept), otherwise drop on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else if (issue_fire) begin
      res_valid_q <= 1'b1;
      res_tag_q   <= ent_q[iss_idx].dest;
      res_data_q  <= lu_y;
    end else if (rs.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Occupancy count: dispatch adds one, issue removes one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (disp_fire && !issue_fire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!disp_fire && issue_fire) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign rs.disp_ready = free_hit;
  assign rs.res_valid  = res_valid_q;
  assign rs.res_tag    = res_tag_q;
  assign rs.res_data   = res_data_q;
  assign busy_cnt      = cnt_q;
endmodule

// File: tb/tb_logic_rs.sv
// Bench for logic_rs: table-driven ops plus hand sequences for wakeup, bypass, full, order, reset.
// Latency: results are checked by a scoreboard as they transfer; timing checked by cycle counts.
// Backpressure: res_ready is held low in the full and reset sequences.
module tb_logic_rs;
  logic       clk;
  logic       rst_n;
  logic [2:0] busy_cnt;

  logic_rs_if #(.TAG_W(4), .DW(64)) bus ();

  logic_rs #(.N_ENT(4), .TAG_W(4), .DW(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs       (bus),
    .busy_cnt (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every transfer must match the oldest expected result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got tag %0h data %0h, want no transfer", bus.res_tag, bus.res_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_tag", 64'(bus.res_tag), 64'(e.tag));
        chk("sb_data", bus.res_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [3:0] dest,
                          input logic [63:0] vj, input logic [63:0] vk,
                          input logic qjv, input logic [3:0] qj,
                          input logic qkv, input logic [3:0] qk,
                          output logic acc);
    bus.disp_valid = 1'b1;
    bus.disp_op    = op;
    bus.disp_dest  = dest;
    bus.disp_vj    = vj;
    bus.disp_vk    = vk;
    bus.disp_qj_v  = qjv;
    bus.disp_qj    = qj;
    bus.disp_qk_v  = qkv;
    bus.disp_qk    = qk;
    acc = bus.disp_ready;
    @(posedge clk);
    #1;
    bus.disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [63:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
    @(posedge clk);
    #1;
    bus.cdb_valid = 1'b0;
  endtask

  // Number of falling edges until res_valid, -1 if the budget runs out
  task automatic cycles_to_valid(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        n = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (sb_q.size() == 0) break;
      idle(1);
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin : main
    logic acc;
    int   n;
    int   acc_cnt;
    int   bad;
    int   streak;

    tbl[0] = '{3'd3, 64'h4,                  64'h10, 4'h1, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{3'd0, 64'hF0F0,               64'hFF00, 4'h2, 64'hF000};
    tbl[2] = '{3'd1, 64'hF0F0,               64'h0F0F, 4'h3, 64'hFFFF};
    tbl[3] = '{3'd2, 64'hFFFF,               64'h00FF, 4'h4, 64'hFF00};
    tbl[4] = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,    4'h5, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[5] = '{3'd5, 64'h0,                  64'h0,    4'h6, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6] = '{3'd6, 64'hFF,                 64'h0F,   4'h7, 64'hF0};
    tbl[7] = '{3'd7, 64'h1234,               64'h5678, 4'h8, 64'h1234};

    bus.disp_valid = 1'b0;
    bus.disp_op    = '0;
    bus.disp_dest  = '0;
    bus.disp_vj    = '0;
    bus.disp_vk    = '0;
    bus.disp_qj_v  = 1'b0;
    bus.disp_qk_v  = 1'b0;
    bus.disp_qj    = '0;
    bus.disp_qk    = '0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.res_ready  = 1'b1;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_tag", 64'(bus.res_tag), 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic op and dispatch-to-result latency
    sb_q.push_back('{4'h6, 64'hFFFF_FFFF_FFFF_FFEB});
    dispatch(3'b011, 4'h6, 64'h4, 64'h10, 1'b0, 4'h0, 1'b0, 4'h0, acc);
    cycles_to_valid(6, n);
    chk("basic_latency", 64'(n), 64'd2);
    wait_drain(10);

    // Table of independent ready ops, back to back
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('{tbl[i].tag, tbl[i].exp});
      dispatch(tbl[i].op, tbl[i].tag, tbl[i].a, tbl[i].b, 1'b0, 4'h0, 1'b0, 4'h0, acc);
      chk("tbl_accept", 64'(acc), 64'd1);
    end
    wait_drain(20);

    // CDB wakeup; a non-matching tag must not wake the entry
    sb_q.push_back('{4'h9, 64'hF0});
    dispatch(3'b000, 4'h9, 64'h0, 64'hFF, 1'b1, 4'h5, 1'b0, 4'h0, acc);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'h6;
        bus.cdb_data  = 64'hFFFF;
      end
      @(negedge clk);
      if (bus.res_valid) bad++;
      @(posedge clk);
      #1;
      bus.cdb_valid = 1'b0;
    end
    chk("wakeup_no_early", 64'(bad), 64'd0);
    cdb(4'h5, 64'hF0);
    cycles_to_valid(6, n);
    chk("wakeup_latency", 64'(n), 64'd2);
    wait_drain(10);

    // Dispatch/CDB bypass on both operands
    sb_q.push_back('{4'hE, 64'hAAAA});
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 4'h7;
    bus.cdb_data  = 64'hAAAA;
    dispatch(3'b001, 4'hE, 64'h0, 64'h0, 1'b1, 4'h7, 1'b1, 4'h7, acc);
    bus.cdb_valid = 1'b0;
    cycles_to_valid(6, n);
    chk("bypass_latency", 64'(n), 64'd2);
    wait_drain(10);

    // Full and backpressure: A issues at once, C reuses entry 0, so drain order is A,C,B,D,E
    bus.res_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      dispatch(3'b111, 4'(k), 64'(k) * 64'h11, 64'h0, 1'b0, 4'h0, 1'b0, 4'h0, acc);
      if (acc) acc_cnt++;
    end
    chk("full_accepted", 64'(acc_cnt), 64'd5);
    chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    chk("full_busy_cnt", 64'(busy_cnt), 64'd4);
    chk("full_res_valid", 64'(bus.res_valid), 64'd1);
    idle(2);
    chk("hold_res_tag", 64'(bus.res_tag), 64'd1);
    chk("hold_res_data", bus.res_data, 64'h11);
    sb_q.push_back('{4'h1, 64'h11});
    sb_q.push_back('{4'h3, 64'h33});
    sb_q.push_back('{4'h2, 64'h22});
    sb_q.push_back('{4'h4, 64'h44});
    sb_q.push_back('{4'h5, 64'h55});
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("full_issue_no_ready", 64'(bus.disp_ready), 64'd0);
    streak = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.res_valid) streak++;
    end
    chk("drain_streak", 64'(streak), 64'd4);
    @(posedge clk);
    #1;
    chk("drained_res_valid", 64'(bus.res_valid), 64'd0);
    chk("drained_busy_cnt", 64'(busy_cnt), 64'd0);
    wait_drain(10);

    // Order and select: only entry 2 ready, then entry 0, then 1 and 3
    sb_q.push_back('{4'h3, 64'hC2});
    sb_q.push_back('{4'h1, 64'hA0});
    sb_q.push_back('{4'h2, 64'hB1});
    sb_q.push_back('{4'h4, 64'hD3});
    dispatch(3'b111, 4'h1, 64'h0,  64'h0, 1'b1, 4'hA, 1'b0, 4'h0, acc);
    dispatch(3'b111, 4'h2, 64'h0,  64'h0, 1'b1, 4'hB, 1'b0, 4'h0, acc);
    dispatch(3'b111, 4'h3, 64'hC2, 64'h0, 1'b0, 4'h0, 1'b0, 4'h0, acc);
    dispatch(3'b111, 4'h4, 64'hD3, 64'h0, 1'b0, 4'h0, 1'b1, 4'hC, acc);
    chk("order_busy_cnt", 64'(busy_cnt), 64'd3);
    cdb(4'hA, 64'hA0);
    cdb(4'hB, 64'hB1);
    cdb(4'hC, 64'h99);
    wait_drain(20);

    // Reset mid-operation, asserted between clock edges
    bus.res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dispatch(3'b111, 4'(k), 64'(k), 64'h0, 1'b0, 4'h0, 1'b0, 4'h0, acc);
    end
    chk("pre_rst_busy_cnt", 64'(busy_cnt), 64'd3);
    chk("pre_rst_res_valid", 64'(bus.res_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mid_rst_res_tag", 64'(bus.res_tag), 64'd0);
    chk("mid_rst_res_data", bus.res_data, 64'd0);
    chk("mid_rst_busy_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    idle(3);
    chk("post_rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("post_rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("post_rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("final_queue", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
